// File: rtl/fanout_pkg.sv
// Shared defaults and token type for the eager-fork fanout controller.
package fanout_pkg;

   localparam int NUM_OUT_DEF = 7;
   localparam int DATA_W_DEF  = 17;
   localparam int CNT_W_DEF   = 16;

   typedef logic [DATA_W_DEF-1:0] token_t;

endpackage

// File: rtl/fanout_fifo2.sv
// Two-entry register FIFO; the registered count keeps the producer side free of any
// combinational dependence on consumer readiness.
module fanout_fifo2
   import fanout_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clk_en,
   input  logic              flush,
   input  logic              push_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] head_o,
   output logic [1:0]        count_o,
   output logic              full_o,
   output logic              empty_o
);

   logic [DATA_W-1:0] mem_q [2];
   logic              wrPtr_q, wrPtr_d;
   logic              rdPtr_q, rdPtr_d;
   logic [1:0]        count_q, count_d;

   // Flush wins over any simultaneous push or pop.
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (flush) begin
         wrPtr_d = 1'b0;
         rdPtr_d = 1'b0;
         count_d = 2'd0;
      end else begin
         if (push_i) wrPtr_d = ~wrPtr_q;
         if (pop_i)  rdPtr_d = ~rdPtr_q;
         case ({push_i, pop_i})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wrPtr_q  <= 1'b0;
         rdPtr_q  <= 1'b0;
         count_q  <= 2'd0;
      end else if (clk_en) begin
         if (push_i && !flush) mem_q[wrPtr_q] <= data_i;
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   assign head_o  = mem_q[rdPtr_q];
   assign count_o = count_q;
   assign full_o  = (count_q == 2'd2);
   assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/fanout_fork_ctrl.sv
// Eager fork: each enabled branch takes the head token once; the head retires when
// every enabled branch has taken it.
module fanout_fork_ctrl
   import fanout_pkg::*;
#(
   parameter int NUM_OUT = NUM_OUT_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clk_en,
   input  logic                      flush,
   input  logic [NUM_OUT-1:0]        cfg_en_mask,
   input  logic [DATA_W-1:0]         in_data,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [NUM_OUT*DATA_W-1:0] out_data,
   output logic [NUM_OUT-1:0]        out_valid,
   input  logic [NUM_OUT-1:0]        out_ready,
   output logic [CNT_W-1:0]          tok_cnt,
   output logic                      busy
);

   logic [DATA_W-1:0]  headData;
   logic [1:0]         fifoCount;
   logic               fifoFull, fifoEmpty;
   logic               headV, push, pop;
   logic [NUM_OUT-1:0] done;
   logic [NUM_OUT-1:0] taken_q, taken_d;
   logic [CNT_W-1:0]   tokCnt_q, tokCnt_d;

   fanout_fifo2 #(.DATA_W(DATA_W)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clk_en  (clk_en),
      .flush   (flush),
      .push_i  (push),
      .data_i  (in_data),
      .pop_i   (pop),
      .head_o  (headData),
      .count_o (fifoCount),
      .full_o  (fifoFull),
      .empty_o (fifoEmpty)
   );

   assign headV     = (fifoCount != 2'd0);
   assign in_ready  = ~fifoFull;
   assign busy      = ~fifoEmpty;
   assign push      = in_valid & in_ready & clk_en;
   assign out_valid = {NUM_OUT{headV}} & cfg_en_mask & ~taken_q;
   assign done      = ~cfg_en_mask | taken_q | out_ready;
   assign pop       = headV & clk_en & (&done);

   for (genvar i = 0; i < NUM_OUT; i++) begin : g_lane
      assign out_data[i*DATA_W +: DATA_W] = headData;
   end

   // Taken flags clear on retire so the next head is offered to every branch afresh.
   always_comb begin
      taken_d  = taken_q;
      tokCnt_d = tokCnt_q;
      if (flush) begin
         taken_d  = '0;
         tokCnt_d = '0;
      end else if (pop) begin
         taken_d = '0;
         if (tokCnt_q != {CNT_W{1'b1}}) tokCnt_d = tokCnt_q + CNT_W'(1);
      end else begin
         taken_d = taken_q | (out_valid & out_ready);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         taken_q  <= '0;
         tokCnt_q <= '0;
      end else if (clk_en) begin
         taken_q  <= taken_d;
         tokCnt_q <= tokCnt_d;
      end
   end

   assign tok_cnt = tokCnt_q;

endmodule

// File: tb/tb_fanout_fork_ctrl.sv
// Directed bench for fanout_fork_ctrl with hand-computed expectations.
module tb_fanout_fork_ctrl;

   localparam int NUM_OUT = 7;
   localparam int DATA_W  = 17;
   localparam int CNT_W   = 16;

   logic                      clk = 1'b0;
   logic                      rst_n = 1'b0;
   logic                      clk_en = 1'b1;
   logic                      flush = 1'b0;
   logic [NUM_OUT-1:0]        cfg_en_mask = '0;
   logic [DATA_W-1:0]         in_data = '0;
   logic                      in_valid = 1'b0;
   logic                      in_ready;
   logic [NUM_OUT*DATA_W-1:0] out_data;
   logic [NUM_OUT-1:0]        out_valid;
   logic [NUM_OUT-1:0]        out_ready = '0;
   logic [CNT_W-1:0]          tok_cnt;
   logic                      busy;

   int vectors = 0;
   int miscompares = 0;

   fanout_fork_ctrl #(.NUM_OUT(NUM_OUT), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clk_en      (clk_en),
      .flush       (flush),
      .cfg_en_mask (cfg_en_mask),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .tok_cnt     (tok_cnt),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [NUM_OUT-1:0] mask, input logic valid,
                                input logic [DATA_W-1:0] data, input logic [NUM_OUT-1:0] ready);
      cfg_en_mask = mask;
      in_valid    = valid;
      in_data     = data;
      out_ready   = ready;
   endtask

   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [127:0] rep(input logic [DATA_W-1:0] tok);
      logic [NUM_OUT*DATA_W-1:0] r;
      r = {NUM_OUT{tok}};
      return 128'(r);
   endfunction

   task automatic doFlush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   initial begin
      // Reset values, observed while reset is held
      #2;
      checkOutput("rst_out_valid", 128'(out_valid), 128'h0);
      checkOutput("rst_busy", 128'(busy), 128'h0);
      checkOutput("rst_in_ready", 128'(in_ready), 128'h1);
      checkOutput("rst_out_data", 128'(out_data), 128'h0);
      checkOutput("rst_tok_cnt", 128'(tok_cnt), 128'h0);
      tick();
      rst_n = 1'b1;
      tick();

      // Full-rate streaming to all seven branches
      applyStimulus(7'h7F, 1'b1, 17'h001, 7'h7F);
      checkOutput("t1_pre_valid", 128'(out_valid), 128'h0);
      tick();
      for (int k = 1; k <= 5; k++) begin
         checkOutput("t1_valid", 128'(out_valid), 128'h7F);
         checkOutput("t1_data", 128'(out_data), rep(DATA_W'(k)));
         checkOutput("t1_in_ready", 128'(in_ready), 128'h1);
         if (k < 5) in_data = DATA_W'(k + 1);
         else       in_valid = 1'b0;
         tick();
      end
      checkOutput("t1_end_valid", 128'(out_valid), 128'h0);
      checkOutput("t1_end_busy", 128'(busy), 128'h0);
      checkOutput("t1_tok_cnt", 128'(tok_cnt), 128'd5);
      doFlush();
      checkOutput("flush_cnt_clear", 128'(tok_cnt), 128'd0);

      // Branch 0 takes early, branch 1 takes three cycles later
      applyStimulus(7'h03, 1'b1, 17'h0AA, 7'h00);
      tick();
      applyStimulus(7'h03, 1'b0, 17'h000, 7'h01);
      checkOutput("t2_c1_valid", 128'(out_valid), 128'h03);
      checkOutput("t2_c1_data", 128'(out_data[DATA_W-1:0]), 128'h0AA);
      tick();
      checkOutput("t2_c2_valid", 128'(out_valid), 128'h02);
      out_ready = 7'h01;
      tick();
      checkOutput("t2_c3_valid", 128'(out_valid), 128'h02);
      out_ready = 7'h00;
      tick();
      checkOutput("t2_c4_valid", 128'(out_valid), 128'h02);
      checkOutput("t2_c4_busy", 128'(busy), 128'h1);
      out_ready = 7'h02;
      tick();
      checkOutput("t2_retired_valid", 128'(out_valid), 128'h0);
      checkOutput("t2_retired_busy", 128'(busy), 128'h0);
      checkOutput("t2_tok_cnt", 128'(tok_cnt), 128'd1);
      doFlush();

      // Backpressure fills the FIFO, then drains in order
      applyStimulus(7'h01, 1'b1, 17'h001, 7'h00);
      tick();
      checkOutput("t3_ready_1", 128'(in_ready), 128'h1);
      in_data = 17'h002;
      tick();
      checkOutput("t3_full_ready", 128'(in_ready), 128'h0);
      checkOutput("t3_full_valid", 128'(out_valid), 128'h01);
      checkOutput("t3_full_head", 128'(out_data[DATA_W-1:0]), 128'h001);
      in_data = 17'h003;
      tick();
      checkOutput("t3_held_ready", 128'(in_ready), 128'h0);
      checkOutput("t3_held_head", 128'(out_data[DATA_W-1:0]), 128'h001);
      out_ready = 7'h01;
      tick();
      checkOutput("t3_head2", 128'(out_data[DATA_W-1:0]), 128'h002);
      checkOutput("t3_ready_again", 128'(in_ready), 128'h1);
      tick();
      in_valid = 1'b0;
      checkOutput("t3_head3", 128'(out_data[DATA_W-1:0]), 128'h003);
      checkOutput("t3_valid3", 128'(out_valid), 128'h01);
      tick();
      checkOutput("t3_busy_end", 128'(busy), 128'h0);
      checkOutput("t3_tok_cnt", 128'(tok_cnt), 128'd3);
      doFlush();

      // Empty mask: tokens retire without any branch seeing them
      applyStimulus(7'h00, 1'b1, 17'h010, 7'h00);
      for (int k = 0; k < 4; k++) begin
         in_data = DATA_W'(17'h010 + k);
         tick();
         checkOutput("t4_valid", 128'(out_valid), 128'h0);
         checkOutput("t4_busy", 128'(busy), 128'h1);
      end
      in_valid = 1'b0;
      tick();
      checkOutput("t4_busy_end", 128'(busy), 128'h0);
      checkOutput("t4_tok_cnt", 128'(tok_cnt), 128'd4);

      // Flush with partial taken flags, first while clock-enable is low
      applyStimulus(7'h7F, 1'b1, 17'h021, 7'h00);
      tick();
      in_data = 17'h022;
      tick();
      applyStimulus(7'h7F, 1'b0, 17'h000, 7'h05);
      tick();
      out_ready = 7'h00;
      checkOutput("t5_taken_valid", 128'(out_valid), 128'h7A);
      checkOutput("t5_full", 128'(in_ready), 128'h0);
      clk_en = 1'b0;
      flush  = 1'b1;
      tick();
      checkOutput("t5_hold_valid", 128'(out_valid), 128'h7A);
      checkOutput("t5_hold_busy", 128'(busy), 128'h1);
      checkOutput("t5_hold_cnt", 128'(tok_cnt), 128'd4);
      clk_en = 1'b1;
      tick();
      flush = 1'b0;
      checkOutput("t5_flush_valid", 128'(out_valid), 128'h0);
      checkOutput("t5_flush_busy", 128'(busy), 128'h0);
      checkOutput("t5_flush_cnt", 128'(tok_cnt), 128'd0);
      checkOutput("t5_flush_ready", 128'(in_ready), 128'h1);

      // Reset mid-token drops the token; taken flags start clean afterwards
      applyStimulus(7'h7F, 1'b1, 17'h055, 7'h00);
      tick();
      in_valid = 1'b0;
      checkOutput("t6_valid_pre", 128'(out_valid), 128'h7F);
      rst_n = 1'b0;
      #1;
      checkOutput("t6_rst_valid", 128'(out_valid), 128'h0);
      checkOutput("t6_rst_busy", 128'(busy), 128'h0);
      checkOutput("t6_rst_ready", 128'(in_ready), 128'h1);
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      checkOutput("t6_no_stale_valid", 128'(out_valid), 128'h0);
      checkOutput("t6_no_stale_busy", 128'(busy), 128'h0);
      applyStimulus(7'h7F, 1'b1, 17'h066, 7'h7F);
      tick();
      in_valid = 1'b0;
      checkOutput("t6_new_valid", 128'(out_valid), 128'h7F);
      checkOutput("t6_new_data", 128'(out_data), rep(17'h066));
      tick();
      checkOutput("t6_new_cnt", 128'(tok_cnt), 128'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fanout_fork_ctrl.md
Name: fanout_fork_ctrl

Overview:
- Eager-fork controller that shares one producer stream between up to NUM_OUT downstream consumers.
- Buffers tokens in a 2-entry FIFO so that in_ready never depends combinationally on any out_ready.
- Each token is presented to every branch enabled in cfg_en_mask. Each branch's acceptance is remembered in a per-branch taken flag.
- The head token retires only once every enabled branch has accepted it.
- Replaces the purely combinational all-ready reduction with a registered, per-branch-tracked fork.

Parameters:
NUM_OUT, 7, number of consumer branches (1..16)
DATA_W, 17, token width (16 data bits plus 1 control bit)
CNT_W, 16, width of the saturating retired-token counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
clk_en  in  1  global clock enable; when low, no state update occurs
flush  in  1  synchronous clear of FIFO, taken flags and counter
cfg_en_mask  in  NUM_OUT  per-branch enable; static while tokens are in flight
in_data  in  DATA_W  producer token
in_valid  in  1  producer valid
in_ready  out  1  FIFO not full
out_data  out  NUM_OUT*DATA_W  head token replicated to every branch
out_valid  out  NUM_OUT  per-branch valid
out_ready  in  NUM_OUT  per-branch ready
tok_cnt  out  CNT_W  number of retired tokens, saturating
busy  out  1  FIFO non-empty

Behaviour:
- Reset (rst_n low, asynchronous):
  - count=0, taken=0, tok_cnt=0, FIFO pointers=0.
  - Outputs: out_valid=0, busy=0, out_data=0, in_ready=1.
- in_ready = (count<2), taken from a registered count. There is no bypass: when full, in_ready=0 even if the head pops in the same cycle.
- push = in_valid & in_ready & clk_en. The token is written at the tail.
- head_v = (count>0). out_data[i] = head token for all i.
- out_valid[i] = head_v & cfg_en_mask[i] & ~taken[i].
- done[i] = ~cfg_en_mask[i] | taken[i] | out_ready[i].
- pop = head_v & clk_en & AND(done).
- Taken-flag update:
  - On pop: taken <= 0.
  - Otherwise, with clk_en: taken <= taken | (out_valid & out_ready).
- Count update:
  - push & pop: unchanged.
  - push only: +1.
  - pop only: -1.
- tok_cnt increments on each pop and saturates at all-ones.
- Latency: in_valid to out_valid is 1 cycle. Throughput is 1 token per cycle when all enabled branches are ready.
- A branch that accepted early keeps out_valid low until the head retires. It never sees the same token twice.
- cfg_en_mask=0: each token retires the cycle after it is pushed, with no out_valid asserted, and tok_cnt still counts it.
- cfg_en_mask changed with head_v=1: newly disabled branches count as done immediately; newly enabled branches receive the current head. Software must not rely on this case.
- flush, synchronous and effective only with clk_en=1: count=0, taken=0, tok_cnt=0. Any push in the same cycle is dropped, and flush has priority over push and pop.
- clk_en=0: all registers hold. Outputs stay combinationally consistent with the held state.
- rst_n asserted mid-token: the token and its taken flags are lost with no partial retire.

Decomposition:
- Package fanout_pkg holds:
  - defaults NUM_OUT_DEF=7, DATA_W_DEF=17, CNT_W_DEF=16;
  - typedef token_t of DATA_W bits.
- Sub-module fanout_fifo2:
  - 2-entry register FIFO with push/pop, count, head data and full/empty outputs;
  - async active-low reset, clk_en and flush inputs.
- fanout_fork_ctrl contains the taken flags, done reduction, pop logic and tok_cnt.

Test Plan:
1. mask=7'h7F, all out_ready=1, push tokens 0x001..0x005 back-to-back -> each out_valid pulses 1 cycle after its push; 5 pops on consecutive cycles; tok_cnt=5; in_ready stays 1.
2. mask=7'h03, push 0x0AA, out_ready[0]=1 at cycle 1 and out_ready[1]=1 only at cycle 4 -> out_valid[0] high cycle 1 only; out_valid[1] high cycles 1-4; pop at cycle 4; tok_cnt=1; no branch sees 0x0AA twice.
3. mask=7'h01, out_ready=0, push 3 tokens -> in_ready=0 after 2 accepted; third push held; raising out_ready drains 0x001 then 0x002, then accepts the third.
4. mask=0, push 4 tokens -> no out_valid; tok_cnt=4; busy returns low 1 cycle after the last push.
5. Two tokens buffered with taken=7'h05, then flush=1 -> next cycle count=0, taken=0, tok_cnt=0, out_valid=0. Repeat with clk_en=0 during flush -> no change.
6. Push 1 token with mask=7'h7F, assert rst_n low mid-wait -> out_valid=0, busy=0 and in_ready=1 immediately; after release, no stale token appears.
